// File: rtl/maze_pkg.sv
// Shared maze-solver definitions: direction encoding and maze-derived sizes.
// Used by the solver controller, the datapath and the move-history deque.
package maze_pkg;

    typedef enum logic [1:0] {
        UP    = 2'b00,
        RIGHT = 2'b01,
        LEFT  = 2'b10,
        DOWN  = 2'b11
    } dir_t;

    localparam int MAZE_DIM    = 16;
    localparam int DEQUE_DEPTH = MAZE_DIM * MAZE_DIM;
    localparam int DIR_W       = $bits(dir_t);

endpackage

// File: rtl/deque_ptr.sv
// Wrapping up/down index register over 0..MAX-1; MAX need not be a power of two.
module deque_ptr #(
    parameter  int MAX = 4,
    localparam int PW  = $clog2(MAX)
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic          clr_i,
    input  logic          inc_i,
    input  logic          dec_i,
    output logic [PW-1:0] ptr_o
);

    localparam logic [PW-1:0] LAST = PW'(MAX - 1);

    logic [PW-1:0] ptr_q, ptr_d;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        ptr_d = ptr_q;
        if (clr_i)
            ptr_d = '0;
        else if (inc_i && !dec_i)
            ptr_d = (ptr_q == LAST) ? '0 : ptr_q + PW'(1);
        else if (dec_i && !inc_i)
            ptr_d = (ptr_q == '0) ? LAST : ptr_q - PW'(1);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst)
            ptr_q <= '0;
        else
            ptr_q <= ptr_d;
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/path_deque.sv
// Double-ended move-history buffer: push at back, LIFO pop for backtracking,
// FIFO pop for path replay. Popped data is registered and appears one cycle later.
module path_deque
    import maze_pkg::*;
#(
    parameter  int WIDTH = DIR_W,
    parameter  int DEPTH = DEQUE_DEPTH,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Clr,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop_back,
    input  logic             pop_front,
    output logic [WIDTH-1:0] back_out,
    output logic [WIDTH-1:0] front_out,
    output logic             back_valid,
    output logic             front_valid,
    output logic             empty,
    output logic             full,
    output logic [CW-1:0]    count,
    output logic             overflow
);

    localparam int            AW      = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0]    head, tail, tail_prev, wr_idx;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] back_out_q, front_out_q;
    logic             back_valid_q, front_valid_q, overflow_q;
    logic             empty_w, full_w;
    logic             do_pop_back, do_pop_front, push_ok, tail_inc, tail_dec;

    assign empty_w   = (count_q == '0);
    assign full_w    = (count_q == DEPTH_C);
    assign tail_prev = (tail == '0) ? AW'(DEPTH - 1) : tail - AW'(1);

    always_comb begin
        do_pop_back  = !Clr && pop_back && !empty_w;
        // With a single entry left, the back pop takes it and the front pop is dropped.
        do_pop_front = !Clr && pop_front && !empty_w && !(do_pop_back && count_q == CW'(1));
        // A push while full is still legal when a pop frees (or replaces) a slot this cycle.
        push_ok      = !Clr && push && (!full_w || do_pop_back || do_pop_front);
        // push + pop_back replaces the back entry in place, so tail stays put.
        tail_inc     = push_ok && !do_pop_back;
        tail_dec     = do_pop_back && !push_ok;
        wr_idx       = do_pop_back ? tail_prev : tail;
        count_d      = count_q;
        if (push_ok)      count_d = count_d + CW'(1);
        if (do_pop_back)  count_d = count_d - CW'(1);
        if (do_pop_front) count_d = count_d - CW'(1);
    end

    deque_ptr #(.MAX(DEPTH)) u_head (
        .Clk   (Clk),
        .Rst   (Rst),
        .clr_i (Clr),
        .inc_i (do_pop_front),
        .dec_i (1'b0),
        .ptr_o (head)
    );

    deque_ptr #(.MAX(DEPTH)) u_tail (
        .Clk   (Clk),
        .Rst   (Rst),
        .clr_i (Clr),
        .inc_i (tail_inc),
        .dec_i (tail_dec),
        .ptr_o (tail)
    );

    // NOTE: the storage array has no reset; count alone decides which slots hold data.
    always_ff @(posedge Clk) begin
        if (push_ok)
            mem[wr_idx] <= din;
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            count_q       <= '0;
            back_out_q    <= '0;
            front_out_q   <= '0;
            back_valid_q  <= 1'b0;
            front_valid_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else if (Clr) begin
            count_q       <= '0;
            back_out_q    <= '0;
            front_out_q   <= '0;
            back_valid_q  <= 1'b0;
            front_valid_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            count_q       <= count_d;
            back_valid_q  <= do_pop_back;
            front_valid_q <= do_pop_front;
            if (do_pop_back)     back_out_q  <= mem[tail_prev];
            if (do_pop_front)    front_out_q <= mem[head];
            if (push && !push_ok) overflow_q <= 1'b1;
        end
    end

    assign back_out    = back_out_q;
    assign front_out   = front_out_q;
    assign back_valid  = back_valid_q;
    assign front_valid = front_valid_q;
    assign empty       = empty_w;
    assign full        = full_w;
    assign count       = count_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_path_deque.sv
// Self-checking bench for path_deque (DEPTH=4): directed scenarios plus a
// randomized run checked against a queue-based reference model.
module tb_path_deque;
    import maze_pkg::*;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          Clk, Rst, Clr, push, pop_back, pop_front;
    logic [1:0]    din;
    logic [1:0]    back_out, front_out;
    logic          back_valid, front_valid, empty, full, overflow;
    logic [CW-1:0] count;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [1:0] mq[$];
    logic [1:0] m_bo, m_fo;
    bit         m_bv, m_fv, m_ovf;

    path_deque #(.WIDTH(2), .DEPTH(DEPTH)) dut (
        .Clk         (Clk),
        .Rst         (Rst),
        .Clr         (Clr),
        .push        (push),
        .din         (din),
        .pop_back    (pop_back),
        .pop_front   (pop_front),
        .back_out    (back_out),
        .front_out   (front_out),
        .back_valid  (back_valid),
        .front_valid (front_valid),
        .empty       (empty),
        .full        (full),
        .count       (count),
        .overflow    (overflow)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic model_reset();
        mq.delete();
        m_bo = 2'b00; m_fo = 2'b00; m_bv = 1'b0; m_fv = 1'b0; m_ovf = 1'b0;
    endtask

    task automatic model_clock(input bit p, input logic [1:0] d, input bit pb, input bit pf, input bit c);
        int n;
        bit pb_ok, pf_ok;
        n = mq.size();
        m_bv = 1'b0;
        m_fv = 1'b0;
        if (c) begin
            model_reset();
            return;
        end
        pb_ok = pb && n > 0;
        pf_ok = pf && (pb_ok ? n >= 2 : n >= 1);
        if (pb_ok) begin m_bo = mq.pop_back();  m_bv = 1'b1; end
        if (pf_ok) begin m_fo = mq.pop_front(); m_fv = 1'b1; end
        if (p) begin
            if (pb_ok || pf_ok || n < DEPTH) mq.push_back(d);
            else m_ovf = 1'b1;
        end
    endtask

    // Drive one cycle starting at a falling edge; returns at the next falling edge.
    task automatic step(input bit p, input logic [1:0] d, input bit pb, input bit pf, input bit c);
        push = p; din = d; pop_back = pb; pop_front = pf; Clr = c;
        @(posedge Clk);
        model_clock(p, d, pb, pf, c);
        @(negedge Clk);
        push = 1'b0; pop_back = 1'b0; pop_front = 1'b0; Clr = 1'b0;
    endtask

    task automatic test_reset();
        n_checks++; if (count !== 3'd0)      begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
        n_checks++; if (empty !== 1'b1)      begin n_fail++; $display("FAIL reset_empty: got %b expected 1", empty); end
        n_checks++; if (full !== 1'b0)       begin n_fail++; $display("FAIL reset_full: got %b expected 0", full); end
        n_checks++; if (overflow !== 1'b0)   begin n_fail++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
        n_checks++; if (back_valid !== 1'b0) begin n_fail++; $display("FAIL reset_back_valid: got %b expected 0", back_valid); end
        n_checks++; if (front_valid !== 1'b0) begin n_fail++; $display("FAIL reset_front_valid: got %b expected 0", front_valid); end
        n_checks++; if (back_out !== 2'b00)  begin n_fail++; $display("FAIL reset_back_out: got %b expected 00", back_out); end
        n_checks++; if (front_out !== 2'b00) begin n_fail++; $display("FAIL reset_front_out: got %b expected 00", front_out); end
    endtask

    task automatic test_lifo();
        logic [1:0] exp_bo [3] = '{2'b10, 2'b01, 2'b00};
        step(1, UP, 0, 0, 0);
        step(1, RIGHT, 0, 0, 0);
        step(1, LEFT, 0, 0, 0);
        n_checks++; if (count !== 3'd3) begin n_fail++; $display("FAIL lifo_fill_count: got %0d expected 3", count); end
        for (int i = 0; i < 3; i++) begin
            step(0, 2'b00, 1, 0, 0);
            n_checks++; if (back_out !== exp_bo[i]) begin n_fail++; $display("FAIL lifo_back_out[%0d]: got %b expected %b", i, back_out, exp_bo[i]); end
            n_checks++; if (back_valid !== 1'b1) begin n_fail++; $display("FAIL lifo_back_valid[%0d]: got %b expected 1", i, back_valid); end
            n_checks++; if (count !== 3'(2 - i)) begin n_fail++; $display("FAIL lifo_count[%0d]: got %0d expected %0d", i, count, 2 - i); end
        end
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL lifo_empty: got %b expected 1", empty); end
        step(0, 2'b00, 0, 0, 0);
        n_checks++; if (back_valid !== 1'b0) begin n_fail++; $display("FAIL lifo_valid_pulse: got %b expected 0", back_valid); end
        n_checks++; if (back_out !== 2'b00) begin n_fail++; $display("FAIL lifo_back_hold: got %b expected 00", back_out); end
    endtask

    task automatic test_fifo();
        logic [1:0] exp_fo [3] = '{2'b00, 2'b01, 2'b11};
        for (int i = 0; i < 3; i++) step(1, exp_fo[i], 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 2'b00, 0, 1, 0);
            n_checks++; if (front_out !== exp_fo[i]) begin n_fail++; $display("FAIL fifo_front_out[%0d]: got %b expected %b", i, front_out, exp_fo[i]); end
            n_checks++; if (front_valid !== 1'b1) begin n_fail++; $display("FAIL fifo_front_valid[%0d]: got %b expected 1", i, front_valid); end
        end
        step(0, 2'b00, 0, 1, 0);
        n_checks++; if (front_valid !== 1'b0) begin n_fail++; $display("FAIL fifo_empty_pop_valid: got %b expected 0", front_valid); end
        n_checks++; if (front_out !== 2'b11) begin n_fail++; $display("FAIL fifo_empty_pop_hold: got %b expected 11", front_out); end
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL fifo_empty_pop_count: got %0d expected 0", count); end
    endtask

    task automatic test_full_wrap();
        logic [1:0] fill [4]  = '{2'b01, 2'b10, 2'b11, 2'b00};
        logic [1:0] drain [4] = '{2'b10, 2'b11, 2'b00, 2'b01};
        for (int i = 0; i < 4; i++) step(1, fill[i], 0, 0, 0);
        n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL full_flag: got %b expected 1", full); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL full_no_overflow: got %b expected 0", overflow); end
        step(1, 2'b10, 0, 0, 0);
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL overflow_set: got %b expected 1", overflow); end
        n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL overflow_count: got %0d expected 4", count); end
        step(1, 2'b01, 0, 1, 0);
        n_checks++; if (front_out !== 2'b01) begin n_fail++; $display("FAIL full_pushpop_front_out: got %b expected 01", front_out); end
        n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL full_pushpop_count: got %0d expected 4", count); end
        n_checks++; if (front_valid !== 1'b1) begin n_fail++; $display("FAIL full_pushpop_valid: got %b expected 1", front_valid); end
        for (int i = 0; i < 4; i++) begin
            step(0, 2'b00, 0, 1, 0);
            n_checks++; if (front_out !== drain[i]) begin n_fail++; $display("FAIL wrap_drain[%0d]: got %b expected %b", i, front_out, drain[i]); end
        end
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL wrap_empty: got %b expected 1", empty); end
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL overflow_sticky: got %b expected 1", overflow); end
    endtask

    task automatic test_replace();
        step(0, 2'b00, 0, 0, 1);
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL clr_overflow: got %b expected 0", overflow); end
        n_checks++; if (front_out !== 2'b00) begin n_fail++; $display("FAIL clr_front_out: got %b expected 00", front_out); end
        step(1, 2'b01, 0, 0, 0);
        step(1, 2'b10, 1, 0, 0);
        n_checks++; if (back_out !== 2'b01) begin n_fail++; $display("FAIL replace_back_out: got %b expected 01", back_out); end
        n_checks++; if (back_valid !== 1'b1) begin n_fail++; $display("FAIL replace_back_valid: got %b expected 1", back_valid); end
        n_checks++; if (count !== 3'd1) begin n_fail++; $display("FAIL replace_count: got %0d expected 1", count); end
        step(0, 2'b00, 0, 1, 0);
        n_checks++; if (front_out !== 2'b10) begin n_fail++; $display("FAIL replace_front_out: got %b expected 10", front_out); end
    endtask

    task automatic test_single_both();
        step(1, 2'b11, 0, 0, 0);
        step(0, 2'b00, 1, 1, 0);
        n_checks++; if (back_out !== 2'b11) begin n_fail++; $display("FAIL single_back_out: got %b expected 11", back_out); end
        n_checks++; if (back_valid !== 1'b1) begin n_fail++; $display("FAIL single_back_valid: got %b expected 1", back_valid); end
        n_checks++; if (front_valid !== 1'b0) begin n_fail++; $display("FAIL single_front_valid: got %b expected 0", front_valid); end
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL single_empty: got %b expected 1", empty); end
        n_checks++; if (front_out !== 2'b10) begin n_fail++; $display("FAIL single_front_hold: got %b expected 10", front_out); end
    endtask

    task automatic test_all_three();
        step(1, 2'b00, 0, 0, 0);
        step(1, 2'b01, 0, 0, 0);
        step(1, 2'b11, 1, 1, 0);
        n_checks++; if (back_out !== 2'b01) begin n_fail++; $display("FAIL three_back_out: got %b expected 01", back_out); end
        n_checks++; if (front_out !== 2'b00) begin n_fail++; $display("FAIL three_front_out: got %b expected 00", front_out); end
        n_checks++; if (count !== 3'd1) begin n_fail++; $display("FAIL three_count: got %0d expected 1", count); end
        step(0, 2'b00, 0, 1, 0);
        n_checks++; if (front_out !== 2'b11) begin n_fail++; $display("FAIL three_remaining: got %b expected 11", front_out); end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 5; i++) step(1, 2'(i), 0, 0, 0);
        step(0, 2'b00, 0, 1, 0);
        #2 Rst = 1'b1;
        #1;
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL async_count: got %0d expected 0", count); end
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL async_empty: got %b expected 1", empty); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL async_overflow: got %b expected 0", overflow); end
        n_checks++; if (front_out !== 2'b00) begin n_fail++; $display("FAIL async_front_out: got %b expected 00", front_out); end
        n_checks++; if (front_valid !== 1'b0) begin n_fail++; $display("FAIL async_front_valid: got %b expected 0", front_valid); end
        model_reset();
        @(negedge Clk);
        Rst = 1'b0;
        for (int i = 0; i < 5; i++) step(1, 2'(i + 1), 0, 0, 0);
        step(1, 2'b10, 0, 0, 1);
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL clr_push_count: got %0d expected 0", count); end
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL clr_push_empty: got %b expected 1", empty); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL clr_push_overflow: got %b expected 0", overflow); end
    endtask

    task automatic test_random();
        bit p, pb, pf, c;
        logic [1:0] d;
        for (int i = 0; i < 1500; i++) begin
            p  = 1'($urandom_range(0, 1));
            pb = ($urandom_range(0, 9) < 3);
            pf = ($urandom_range(0, 9) < 3);
            c  = ($urandom_range(0, 99) == 0);
            d  = 2'($urandom_range(0, 3));
            step(p, d, pb, pf, c);
            n_checks++; if (count !== CW'(mq.size())) begin n_fail++; $display("FAIL rand_count @%0d: got %0d expected %0d", i, count, mq.size()); end
            n_checks++; if (empty !== (mq.size() == 0)) begin n_fail++; $display("FAIL rand_empty @%0d: got %b", i, empty); end
            n_checks++; if (full !== (mq.size() == DEPTH)) begin n_fail++; $display("FAIL rand_full @%0d: got %b", i, full); end
            n_checks++; if (overflow !== m_ovf) begin n_fail++; $display("FAIL rand_overflow @%0d: got %b expected %b", i, overflow, m_ovf); end
            n_checks++; if (back_valid !== m_bv) begin n_fail++; $display("FAIL rand_back_valid @%0d: got %b expected %b", i, back_valid, m_bv); end
            n_checks++; if (front_valid !== m_fv) begin n_fail++; $display("FAIL rand_front_valid @%0d: got %b expected %b", i, front_valid, m_fv); end
            n_checks++; if (back_out !== m_bo) begin n_fail++; $display("FAIL rand_back_out @%0d: got %b expected %b", i, back_out, m_bo); end
            n_checks++; if (front_out !== m_fo) begin n_fail++; $display("FAIL rand_front_out @%0d: got %b expected %b", i, front_out, m_fo); end
        end
    endtask

    initial begin
        Rst = 1'b1; Clr = 1'b0; push = 1'b0; din = 2'b00; pop_back = 1'b0; pop_front = 1'b0;
        model_reset();
        repeat (2) @(negedge Clk);
        test_reset();
        Rst = 1'b0;
        test_lifo();
        test_fifo();
        test_full_wrap();
        test_replace();
        test_single_both();
        test_all_three();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
